// File: rtl/row_scan_decoder_pkg.sv
// Shared types and helpers for the row-scan decoder.
//   decoder_mode_t : direct decode vs. automatic row scan
//   onehot()       : index -> one-hot vector (MAX_W wide, callers truncate)
//   cnt_width()    : dwell counter width, never below 1 bit
package decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } decoder_mode_t;

  localparam int unsigned MAX_N = 8;
  localparam int unsigned MAX_W = 256;

  // One-hot of idx, full MAX_W width.
  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] idx);
    return MAX_W'(1) << idx;
  endfunction

  // Width of a counter that must reach dwell-1.
  function automatic int unsigned cnt_width(input int unsigned dwell);
    return (dwell > 1) ? int'($clog2(dwell)) : 1;
  endfunction

endpackage

// File: rtl/row_scan_decoder_if.sv
// Control/status bundle between a row-select controller and the decoder.
//   master : drives ena, mode, sync, in; observes out, row, frame_done
//   slave  : the decoder side
interface row_scan_decoder_if #(
  parameter int unsigned N = 3
) ();

  logic                      ena;
  decoder_pkg::decoder_mode_t mode;
  logic                      sync;
  logic [N-1:0]              in;
  logic [(2**N)-1:0]         out;
  logic [N-1:0]              row;
  logic                      frame_done;

  modport master (
    output ena, mode, sync, in,
    input  out, row, frame_done
  );

  modport slave (
    input  ena, mode, sync, in,
    output out, row, frame_done
  );

endinterface

// File: rtl/row_scan_decoder_dec.sv
// Combinational N-to-2^N one-hot decoder with enable.
//   ena_i : 0 forces an all-zero output
//   in_i  : select index
//   out_o : one-hot of in_i, or zero
module decoder_n_to_2n
  import decoder_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic              ena_i,
  input  logic [N-1:0]      in_i,
  output logic [(2**N)-1:0] out_o
);

  localparam int unsigned W = 2**N;

  always_comb begin
    out_o = '0;
    if (ena_i) begin
      out_o = W'(onehot(MAX_N'(in_i)));
    end
  end

endmodule

// File: rtl/row_scan_decoder.sv
// Registered one-hot row select for the LED matrix, with direct and
// auto-scan modes.
//   clk, rst       : clock, synchronous active-high reset
//   bus.ena        : 0 blanks out and freezes row/dwell
//   bus.mode       : MODE_DIRECT registers decode of bus.in; MODE_SCAN walks rows
//   bus.sync       : restart scan at row 0 with a fresh dwell
//   bus.out        : registered one-hot row select
//   bus.row        : registered row index
//   bus.frame_done : one-cycle pulse when the scan wraps to row 0
module row_scan_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  row_scan_decoder_if.slave    bus
);

  localparam int unsigned W  = 2**N;
  localparam int unsigned CW = cnt_width(DWELL);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  logic [N-1:0]  row_q, row_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [W-1:0]  out_q, out_d;
  logic          fd_q, fd_d;
  logic          dec_en_c;

  // Next row/dwell; priority sync > disable > mode behaviour.
  always_comb begin
    row_d    = row_q;
    dwell_d  = dwell_q;
    fd_d     = 1'b0;
    dec_en_c = 1'b0;
    if (bus.sync) begin
      row_d    = '0;
      dwell_d  = '0;
      dec_en_c = bus.ena;
    end else if (bus.ena) begin
      dec_en_c = 1'b1;
      if (bus.mode == MODE_DIRECT) begin
        row_d   = bus.in;
        dwell_d = '0;
      end else if (dwell_q < DWELL_LAST) begin
        dwell_d = dwell_q + CW'(1);
      end else begin
        // Row index wraps naturally at 2^N.
        dwell_d = '0;
        row_d   = row_q + N'(1);
        fd_d    = (row_q == '1);
      end
    end
  end

  // Decode the next row so out lines up with row in the same cycle.
  decoder_n_to_2n #(.N(N)) u_dec (
    .ena_i (dec_en_c),
    .in_i  (row_d),
    .out_o (out_d)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      dwell_q <= '0;
      out_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      row_q   <= row_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.row        = row_q;
  assign bus.frame_done = fd_q;

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    assert (N >= 1 && N <= MAX_N) else $error("row_scan_decoder: N out of range");
    assert (DWELL >= 1) else $error("row_scan_decoder: DWELL must be >= 1");
  end
`endif

endmodule

// File: tb/tb_row_scan_decoder.sv
// Bench for row_scan_decoder: table vectors, hand sequences, random vs. model.
module tb_row_scan_decoder;
  import decoder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  row_scan_decoder_if #(.N(3)) bus_a ();
  row_scan_decoder_if #(.N(2)) bus_b ();

  row_scan_decoder #(.N(3), .DWELL(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  row_scan_decoder #(.N(2), .DWELL(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  // Current stimulus, shared by both DUTs.
  logic          s_rst, s_ena, s_sync;
  decoder_mode_t s_mode;
  int            s_in;

  // Model state: position inside the frame in enabled scan steps.
  int pos_a = 0, pos_b = 0;
  int er_a, eo_a, ef_a, er_b, eo_b, ef_b;

  typedef struct {
    logic          rst;
    logic          ena;
    logic          sync;
    decoder_mode_t mode;
    int            in;
    int            e_out;
    int            e_row;
    int            e_fd;
  } vec_t;
  vec_t vecs[20];

  task automatic drive(input logic r, input logic e, input logic s,
                       input decoder_mode_t m, input int in);
    s_rst = r; s_ena = e; s_sync = s; s_mode = m; s_in = in;
    rst = r;
    bus_a.ena = e; bus_a.sync = s; bus_a.mode = m; bus_a.in = 3'(in);
    bus_b.ena = e; bus_b.sync = s; bus_b.mode = m; bus_b.in = 2'(in);
  endtask

  // Frame of R rows x D dwell; row is simply pos / D.
  task automatic model(input int R, input int D, input int in,
                       inout int pos, output int er, output int eo, output int ef);
    eo = 0; ef = 0;
    if (s_rst) begin
      pos = 0;
    end else if (s_sync) begin
      pos = 0;
      eo  = s_ena ? 1 : 0;
    end else if (s_ena) begin
      if (s_mode == MODE_DIRECT) begin
        pos = in * D;
      end else begin
        pos = (pos + 1) % (R * D);
        ef  = (pos == 0) ? 1 : 0;
      end
      eo = 1 << (pos / D);
    end
    er = pos / D;
  endtask

  // Advance one clock; outputs sampled 1 time unit after the edge.
  task automatic cycle();
    model(8, 4, s_in % 8, pos_a, er_a, eo_a, ef_a);
    model(4, 1, s_in % 4, pos_b, er_b, eo_b, ef_b);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string tag, input int eo, input int er, input int ef);
    chk({tag, " a.out"}, int'(bus_a.out), eo);
    chk({tag, " a.row"}, int'(bus_a.row), er);
    chk({tag, " a.frame_done"}, int'(bus_a.frame_done), ef);
  endtask

  task automatic chk_b(input string tag, input int eo, input int er, input int ef);
    chk({tag, " b.out"}, int'(bus_b.out), eo);
    chk({tag, " b.row"}, int'(bus_b.row), er);
    chk({tag, " b.frame_done"}, int'(bus_b.frame_done), ef);
  endtask

  initial begin
    int fd_count;

    drive(1'b1, 1'b1, 1'b0, MODE_DIRECT, 0);

    // Reset, direct sweep enabled/disabled, sync with and without ena.
    for (int i = 0; i < 2; i++) vecs[i] = '{1'b1, 1'b1, 1'b0, MODE_DIRECT, 5, 0, 0, 0};
    for (int i = 0; i < 8; i++) vecs[2 + i]  = '{1'b0, 1'b1, 1'b0, MODE_DIRECT, i, 1 << i, i, 0};
    for (int i = 0; i < 8; i++) vecs[10 + i] = '{1'b0, 1'b0, 1'b0, MODE_DIRECT, i, 0, 7, 0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, MODE_SCAN, 3, 0, 0, 0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, MODE_SCAN, 3, 1, 0, 0};

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].ena, vecs[i].sync, vecs[i].mode, vecs[i].in);
      cycle();
      chk_a($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_row, vecs[i].e_fd);
    end

    // Full scan: each row held 4 edges, one frame pulse at edge 32.
    drive(1'b1, 1'b1, 1'b0, MODE_SCAN, 0);
    cycle();
    chk_a("scan reset", 0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, MODE_SCAN, 0);
    fd_count = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      chk_a($sformatf("scan k%0d", k), 1 << ((k / 4) % 8), (k / 4) % 8, (k % 32 == 0) ? 1 : 0);
      fd_count += int'(bus_a.frame_done);
    end
    chk("scan frame_done count", fd_count, 1);

    // Enable gap at row 5, dwell 2.
    drive(1'b1, 1'b1, 1'b0, MODE_SCAN, 0);
    cycle();
    drive(1'b0, 1'b1, 1'b0, MODE_SCAN, 0);
    for (int k = 0; k < 22; k++) cycle();
    chk_a("gap start", 1 << 5, 5, 0);
    drive(1'b0, 1'b0, 1'b0, MODE_SCAN, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk_a("gap off", 0, 5, 0);
    end
    drive(1'b0, 1'b1, 1'b0, MODE_SCAN, 0);
    cycle();
    chk_a("gap resume1", 1 << 5, 5, 0);
    cycle();
    chk_a("gap resume2", 1 << 6, 6, 0);

    // Sync at row 7 dwell 3 suppresses the wrap pulse.
    drive(1'b1, 1'b1, 1'b0, MODE_SCAN, 0);
    cycle();
    drive(1'b0, 1'b1, 1'b0, MODE_SCAN, 0);
    for (int k = 0; k < 31; k++) cycle();
    chk_a("pre sync", 1 << 7, 7, 0);
    drive(1'b0, 1'b1, 1'b1, MODE_SCAN, 0);
    cycle();
    chk_a("sync wrap", 1, 0, 0);
    drive(1'b0, 1'b1, 1'b0, MODE_SCAN, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk_a("post sync", 1, 0, 0);
    end
    cycle();
    chk_a("post sync row1", 2, 1, 0);
    drive(1'b0, 1'b0, 1'b1, MODE_SCAN, 0);
    cycle();
    chk_a("sync no ena", 0, 0, 0);

    // DWELL = 1, N = 2: row advances every enabled edge.
    drive(1'b1, 1'b1, 1'b0, MODE_SCAN, 0);
    cycle();
    chk_b("b reset", 0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, MODE_SCAN, 0);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      chk_b($sformatf("b k%0d", k), 1 << (k % 4), k % 4, (k % 4 == 0) ? 1 : 0);
    end

    // Random traffic against the frame-position model.
    for (int k = 0; k < 800; k++) begin
      drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 75) ? MODE_SCAN : MODE_DIRECT,
            int'($urandom_range(0, 7)));
      cycle();
      chk_a("rand", eo_a, er_a, ef_a);
      chk_b("rand", eo_b, er_b, ef_b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
